// File: rtl/pixel_block_assembler_pkg.sv
// Shared types and constants for the pixel block assembler.
// Block layout matches the edge_detection_filter input vector.
package pixel_block_assembler_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int BLK_DIM_DEF = 8;
  localparam int IDX_W_DEF   = 16;
  localparam int BLK_PIX     = BLK_DIM_DEF * BLK_DIM_DEF;
  localparam int BLK_W       = PIX_W_DEF * BLK_PIX;

  typedef logic [BLK_W-1:0] blk_vec_t;

  // Row-major pixel position inside a block
  function automatic int pix_idx(
    input int r,
    input int c,
    input int dim
  );
    return r * dim + c;
  endfunction

endpackage

// File: rtl/pixel_block_assembler_bank.sv
// One block bank: single write port, whole block readable in parallel.
// Contents are deliberately not reset.
module block_bank_ram
  import pixel_block_assembler_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int BLK_DIM = BLK_DIM_DEF,
  localparam int NPIX   = BLK_DIM * BLK_DIM,
  localparam int AW     = $clog2(NPIX)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [PIX_W-1:0]      din,
  output logic [PIX_W*NPIX-1:0] rd
);

  logic [PIX_W-1:0] mem [NPIX];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  for (genvar r = 0; r < BLK_DIM; r++) begin : g_row
    for (genvar c = 0; c < BLK_DIM; c++) begin : g_col
      localparam int P = pix_idx(r, c, BLK_DIM);
      assign rd[P*PIX_W +: PIX_W] = mem[P];
    end
  end

endmodule

// File: rtl/pixel_block_assembler.sv
// Ping-pong assembler: raster pixel stream in, whole 8x8 blocks out.
// One bank fills while the other is held for the downstream filter.
module pixel_block_assembler
  import pixel_block_assembler_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int BLK_DIM = BLK_DIM_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  localparam int NPIX   = BLK_DIM * BLK_DIM,
  localparam int OUT_W  = PIX_W * NPIX,
  localparam int CNT_W  = $clog2(NPIX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [OUT_W-1:0] blk_out,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [IDX_W-1:0] blk_index,
  output logic             busy
);

  logic [CNT_W-1:0] wr_cnt;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic             accept;
  logic             last;
  logic             consume;
  logic [OUT_W-1:0] q [2];

  // Held low during reset so nothing is accepted before release
  assign pix_ready = reset & ~full[wr_bank];
  assign accept    = pix_valid & pix_ready;
  assign last      = accept & (wr_cnt == CNT_W'(NPIX - 1));
  assign blk_valid = full[rd_bank];
  assign consume   = blk_valid & blk_ready;
  assign blk_out   = q[rd_bank];
  assign busy      = (|full) | (wr_cnt != '0);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    block_bank_ram #(
      .PIX_W   (PIX_W),
      .BLK_DIM (BLK_DIM)
    ) u_bank (
      .clk  (clk),
      .we   (accept & (wr_bank == 1'(b))),
      .addr (wr_cnt),
      .din  (pix_in),
      .rd   (q[b])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      blk_index <= '0;
    end else begin
      if (accept) wr_cnt <= last ? '0 : wr_cnt + 1'b1;
      if (last) wr_bank <= ~wr_bank;
      if (consume) begin
        rd_bank   <= ~rd_bank;
        blk_index <= blk_index + 1'b1;
      end
      // Set and clear never hit the same bank in one cycle
      for (int b = 0; b < 2; b++) begin
        if (last && wr_bank == 1'(b))
          full[b] <= 1'b1;
        else if (consume && rd_bank == 1'(b))
          full[b] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_block_assembler.sv
// Scoreboard bench for pixel_block_assembler: directed cases plus
// randomized handshakes against a queue-based block model.
module tb_pixel_block_assembler;

  localparam int NPIX = 64;
  localparam int OW   = 8 * NPIX;

  typedef struct {
    logic [OW-1:0] data;
    logic [15:0]   idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [OW-1:0] blk_out;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [15:0]   blk_index;
  logic          busy;

  pixel_block_assembler dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .blk_out   (blk_out),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_index (blk_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int exp_idx = 0;
  exp_t expq[$];
  logic [7:0] cur[$];

  logic          hold = 1'b0;
  logic [OW-1:0] hold_blk;

  task automatic check(input string n, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  // Reference: gather accepted pixels; every 64 form the next block
  task automatic model_push(input logic [7:0] p);
    logic [OW-1:0] v;
    exp_t e;
    cur.push_back(p);
    if (cur.size() == NPIX) begin
      for (int i = 0; i < NPIX; i++) v[i*8 +: 8] = cur[i];
      e.data = v;
      e.idx  = 16'(exp_idx);
      expq.push_back(e);
      exp_idx++;
      cur.delete();
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit br);
    pix_valid = v;
    pix_in    = d;
    blk_ready = br;
    if (v && pix_ready) begin
      model_push(d);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    pix_valid = 1'b0;
    blk_ready = 1'b0;
    expq.delete();
    cur.delete();
    exp_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", 64'(pix_ready), 0);
    check("rst_blk_valid", 64'(blk_valid), 0);
    reset = 1'b1;
    #1;
    check("rel_busy", 64'(busy), 0);
    check("rel_blk_valid", 64'(blk_valid), 0);
    check("rel_blk_index", 64'(blk_index), 0);
    check("rel_pix_ready", 64'(pix_ready), 1);
  endtask

  task automatic drain(input string n);
    int k;
    k = 0;
    while ((expq.size() != 0 || blk_valid) && k < 300) begin
      cyc(1'b0, 8'h00, 1'b1);
      k++;
    end
    blk_ready = 1'b0;
    check({n, "_drain_q"}, 64'(expq.size()), 0);
    check({n, "_drain_valid"}, 64'(blk_valid), 0);
  endtask

  // Monitor: compare held block with scoreboard head, pop on consume
  always @(negedge clk) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        tests++;
        if (!blk_valid || blk_out !== hold_blk) begin
          fails++;
          $display("FAIL stable: valid=%0b out changed while stalled", blk_valid);
        end
      end
      if (blk_valid) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_block: index %0d with empty scoreboard", blk_index);
        end else begin
          if (blk_out !== expq[0].data) begin
            fails++;
            $display("FAIL blk_data: got %0h expected %0h", blk_out, expq[0].data);
          end
          tests++;
          if (blk_index !== expq[0].idx) begin
            fails++;
            $display("FAIL blk_index: got %0d expected %0d", blk_index, expq[0].idx);
          end
          if (blk_ready) void'(expq.pop_front());
        end
      end
      hold     = blk_valid & ~blk_ready;
      hold_blk = blk_out;
    end
  end

  initial begin
    do_reset();

    for (int i = 0; i < 63; i++) cyc(1'b1, 8'(i), 1'b0);
    check("t1_pre_valid", 64'(blk_valid), 0);
    cyc(1'b1, 8'd63, 1'b0);
    check("t1_valid", 64'(blk_valid), 1);
    check("t1_index", 64'(blk_index), 0);
    check("t1_ready", 64'(pix_ready), 1);
    check("t1_pix_3_5", 64'(blk_out[(3*8+5)*8 +: 8]), 29);

    for (int i = 64; i < 128; i++) cyc(1'b1, 8'(i), 1'b0);
    check("t2_stall", 64'(pix_ready), 0);
    check("t2_busy", 64'(busy), 1);
    repeat (3) cyc(1'b1, 8'd128, 1'b0);
    cyc(1'b1, 8'd128, 1'b1);
    check("t2_index", 64'(blk_index), 1);
    check("t2_ready", 64'(pix_ready), 1);
    acc_cnt = 0;
    cyc(1'b1, 8'd128, 1'b0);
    check("t2_accept128", 64'(acc_cnt), 1);
    drain("t2");

    do_reset();
    acc_cnt = 0;
    repeat (640) cyc(1'b1, 8'($urandom), 1'b1);
    check("t3_accepted", 64'(acc_cnt), 640);
    drain("t3");
    check("t3_index", 64'(blk_index), 10);

    do_reset();
    repeat (3000)
      cyc(($urandom % 2) == 0, 8'($urandom), ($urandom % 10) < 3);
    drain("t4");

    do_reset();
    for (int i = 0; i < 104; i++) cyc(1'b1, 8'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 63; i++) cyc(1'b1, 8'($urandom), 1'b0);
    check("t5_no_stale", 64'(blk_valid), 0);
    cyc(1'b1, 8'($urandom), 1'b0);
    check("t5_valid", 64'(blk_valid), 1);
    check("t5_index", 64'(blk_index), 0);
    drain("t5");

    do_reset();
    for (int i = 0; i < 127; i++) cyc(1'b1, 8'($urandom), 1'b0);
    cyc(1'b1, 8'($urandom), 1'b1);
    check("t6_valid", 64'(blk_valid), 1);
    check("t6_index", 64'(blk_index), 1);
    check("t6_ready", 64'(pix_ready), 1);
    check("t6_q", 64'(expq.size()), 1);
    drain("t6");
    check("t6_final_index", 64'(blk_index), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
